// File: rtl/serial_operand_loader_if.sv
// Handshake/bus bundle for serial_operand_loader.
//   enable    : bit-strobe; shifting and counting happen only on enabled cycles
//   ser_in    : one serial bit per lane, MSB first
//   start     : frame start; the accepted start cycle carries the MSB
//   out_ready : consumer accepts the presented operands
//   out_valid : operands hold a complete frame
//   operands  : lane i at [i*WIDTH +: WIDTH]
//   busy      : frame in progress
//   overrun   : sticky flag, a start was dropped
// The master modport is the stimulus/consumer side, the slave modport is the loader.
interface serial_operand_loader_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LANES = 3
);
  logic                   enable;
  logic [LANES-1:0]       ser_in;
  logic                   start;
  logic                   out_ready;
  logic                   out_valid;
  logic [LANES*WIDTH-1:0] operands;
  logic                   busy;
  logic                   overrun;

  modport master (
    output enable,
    output ser_in,
    output start,
    output out_ready,
    input  out_valid,
    input  operands,
    input  busy,
    input  overrun
  );

  modport slave (
    input  enable,
    input  ser_in,
    input  start,
    input  out_ready,
    output out_valid,
    output operands,
    output busy,
    output overrun
  );
endinterface

// File: rtl/serial_operand_loader.sv
// serial_operand_loader
//   Deserialises LANES one-bit serial streams (MSB first) into WIDTH-bit operands and
//   presents the complete frame with a valid/ready handshake. The assembled frame is held
//   stable until it is consumed, so downstream arithmetic only ever sees whole operands.
// Ports
//   clk    : clock, all logic on the rising edge
//   reset  : synchronous, active-high; overrides every other input
//   bus_io : serial_operand_loader_if slave modport (enable, ser_in, start, out_ready in;
//            out_valid, operands, busy, overrun out)
module serial_operand_loader #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LANES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_operand_loader_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } state_e;

  state_e                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [LANES-1:0][WIDTH-1:0]     shadow_q, shadow_d;
  logic [LANES-1:0][WIDTH-1:0]     shadow_shifted;
  logic [LANES*WIDTH-1:0]          operands_q, operands_d;
  logic                            out_valid_q, out_valid_d;
  logic                            overrun_q, overrun_d;

  // Every lane shifts in its serial bit at the LSB; after WIDTH shifts the first
  // (MSB) bit has reached the top and all bits of any earlier frame are gone.
  always_comb begin
    shadow_shifted = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      shadow_shifted[i] = {shadow_q[i][WIDTH-2:0], bus_io.ser_in[i]};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    operands_d  = operands_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      StIdle: begin
        // A start without a bit strobe is simply not taken; it is not an overrun.
        if (bus_io.start && bus_io.enable) begin
          shadow_d = shadow_shifted;
          cnt_d    = CntW'(1);
          state_d  = StShift;
        end
      end

      StShift: begin
        if (bus_io.start) begin
          overrun_d = 1'b1;
        end
        if (bus_io.enable) begin
          shadow_d = shadow_shifted;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            // This enabled cycle carries the last bit: publish the whole frame at once.
            operands_d  = shadow_shifted;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = StHold;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StHold: begin
        if (bus_io.out_ready) begin
          out_valid_d = 1'b0;
          if (bus_io.start && bus_io.enable) begin
            // Consume and restart in the same cycle, no bubble for back-to-back frames.
            shadow_d = shadow_shifted;
            cnt_d    = CntW'(1);
            state_d  = StShift;
          end else begin
            state_d = StIdle;
          end
        end else if (bus_io.start) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shadow_q    <= '0;
      operands_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      operands_q  <= operands_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.operands  = operands_q;
  assign bus_io.busy      = (state_q == StShift);
  assign bus_io.overrun   = overrun_q;

endmodule

// File: tb/tb_serial_operand_loader.sv
module tb_serial_operand_loader;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_operand_loader_if #(.WIDTH(6), .LANES(3)) bus ();

  serial_operand_loader #(.WIDTH(6), .LANES(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame f = {lane2, lane1, lane0}; serial bit k (k=0 is the MSB) of every lane.
  function automatic logic [2:0] ser_bits(input logic [17:0] f, input int k);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = f[i*6 + 5 - k];
    return r;
  endfunction

  // Sends one frame from IDLE; returns in the first HOLD cycle.
  task automatic send_frame(input string tag, input logic [17:0] f, input bit gaps,
                            input bit rdy);
    for (int k = 0; k < 6; k++) begin
      bus.start     = (k == 0);
      bus.enable    = 1'b1;
      bus.ser_in    = ser_bits(f, k);
      bus.out_ready = rdy;
      tick();
      if (k < 5) begin
        check({tag, " busy"}, bus.busy, 1);
        check({tag, " valid low"}, bus.out_valid, 0);
        if (gaps) begin
          bus.start  = 1'b0;
          bus.enable = 1'b0;
          bus.ser_in = ~ser_bits(f, k);
          tick();
          check({tag, " busy gap"}, bus.busy, 1);
          check({tag, " valid low gap"}, bus.out_valid, 0);
        end
      end
    end
    bus.start  = 1'b0;
    bus.enable = 1'b0;
    check({tag, " valid"}, bus.out_valid, 1);
    check({tag, " operands"}, bus.operands, f);
    check({tag, " busy done"}, bus.busy, 0);
  endtask

  localparam logic [17:0] F1 = {6'h3F, 6'h07, 6'h2D};
  localparam logic [17:0] F3 = {6'h33, 6'h2A, 6'h15};
  localparam logic [17:0] FR = {6'h2A, 6'h15, 6'h3F};
  localparam logic [17:0] F5 = {6'h01, 6'h3E, 6'h24};
  localparam logic [17:0] FA = {6'h12, 6'h34, 6'h0F};
  localparam logic [17:0] FB = {6'h2B, 6'h1C, 6'h30};

  initial begin
    logic [17:0] exp_q[$];
    logic [17:0] cur;
    logic [17:0] exp_f;
    bit          sending;
    int          nbits, started, received, cyc;

    // Reset
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.start     = 1'b0;
    bus.ser_in    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst valid", bus.out_valid, 0);
    check("rst operands", bus.operands, 0);
    check("rst busy", bus.busy, 0);
    check("rst overrun", bus.overrun, 0);
    reset = 1'b0;
    tick();

    // 1: continuous enable, valid exactly one cycle, back to IDLE
    send_frame("t1", F1, 1'b0, 1'b1);
    tick();
    check("t1 valid drop", bus.out_valid, 0);
    check("t1 idle", bus.busy, 0);
    check("t1 operands kept", bus.operands, F1);
    tick();

    // 2: enable low every other cycle
    send_frame("t2", F1, 1'b1, 1'b1);
    tick();
    check("t2 valid drop", bus.out_valid, 0);

    // 3: stall in HOLD, dropped start sets sticky overrun
    send_frame("t3", F3, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      bus.start     = (j == 2);
      bus.enable    = 1'b1;
      bus.ser_in    = 3'b111;
      bus.out_ready = 1'b0;
      tick();
      check("t3 hold valid", bus.out_valid, 1);
      check("t3 hold operands", bus.operands, F3);
      check("t3 hold busy", bus.busy, 0);
      check("t3 overrun", bus.overrun, (j >= 2));
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t3 valid drop", bus.out_valid, 0);
    check("t3 overrun sticky", bus.overrun, 1);
    bus.out_ready = 1'b0;
    tick();
    check("t3 overrun sticky2", bus.overrun, 1);

    // 5: reset at bit 3 of a frame, then a clean frame
    for (int k = 0; k < 3; k++) begin
      bus.start  = (k == 0);
      bus.enable = 1'b1;
      bus.ser_in = ser_bits(FR, k);
      tick();
    end
    check("t5 busy pre", bus.busy, 1);
    bus.start  = 1'b0;
    bus.ser_in = ser_bits(FR, 3);
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    check("t5 rst valid", bus.out_valid, 0);
    check("t5 rst operands", bus.operands, 0);
    check("t5 rst busy", bus.busy, 0);
    check("t5 rst overrun", bus.overrun, 0);
    bus.enable = 1'b0;
    tick();
    check("t5 still idle", bus.busy, 0);
    send_frame("t5", F5, 1'b0, 1'b1);
    tick();
    check("t5 valid drop", bus.out_valid, 0);

    // 4: handshake and new start in the same HOLD cycle
    send_frame("t4a", FA, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.enable    = 1'b1;
    bus.ser_in    = ser_bits(FB, 0);
    tick();
    check("t4 valid drop", bus.out_valid, 0);
    check("t4 busy", bus.busy, 1);
    check("t4 no overrun", bus.overrun, 0);
    check("t4 operands kept", bus.operands, FA);
    for (int k = 1; k < 6; k++) begin
      bus.start  = 1'b0;
      bus.ser_in = ser_bits(FB, k);
      tick();
      check("t4 valid", bus.out_valid, (k == 5));
    end
    check("t4 operands", bus.operands, FB);
    check("t4 overrun", bus.overrun, 0);
    bus.enable = 1'b0;
    tick();
    check("t4 valid drop2", bus.out_valid, 0);

    // 6: 100 random frames, random enable/out_ready, scoreboard
    sending  = 1'b0;
    nbits    = 0;
    started  = 0;
    received = 0;
    cyc      = 0;
    cur      = '0;
    while (received < 100 && cyc < 20000) begin
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.enable    = ($urandom_range(0, 9) < 7);
      bus.ser_in    = 3'($urandom);
      if (!sending && started < 100 && (!bus.out_valid || bus.out_ready))
        bus.start = 1'($urandom_range(0, 1));
      else
        bus.start = 1'b0;

      // Handshake at the coming edge consumes the frame currently presented.
      if (bus.out_valid && bus.out_ready) begin
        check("t6 frame expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_f = exp_q.pop_front();
          check("t6 frame data", bus.operands, exp_f);
        end
        received++;
      end

      if (!sending && bus.start && bus.enable) begin
        for (int i = 0; i < 3; i++) cur[i*6 +: 6] = {cur[i*6 +: 5], bus.ser_in[i]};
        sending = 1'b1;
        nbits   = 1;
        started++;
      end else if (sending && bus.enable) begin
        for (int i = 0; i < 3; i++) cur[i*6 +: 6] = {cur[i*6 +: 5], bus.ser_in[i]};
        nbits++;
        if (nbits == 6) begin
          exp_q.push_back(cur);
          sending = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    check("t6 frames received", received, 100);
    check("t6 queue empty", exp_q.size(), 0);
    check("t6 no overrun", bus.overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
